// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM encodings and the round-robin pointer helper for sram_arbiter.
// ST_INIT is only reachable when SRAM_ARB_CLEAR_EN is defined.
package sram_arb_pkg;

    localparam int SRAM_AW_DEF = 9;
    localparam int SRAM_DW_DEF = 9;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_ARB  = 1'b1;

    // Pointer value after granting idx: one past the winner, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Rotating-priority encoder: the first valid bit at or above ptr (with wrap) wins.
// Purely combinational, zero latency; applies no backpressure of its own.
module rr_grant #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);
    int            j;
    logic [PW-1:0] sel;

    // Walk offsets from the far end so the nearest valid to ptr is assigned last.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        sel   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            sel = PW'(j);
            if (valid[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                idx        = sel;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter onto one single-port SRAM; SRAM outputs registered, reads return 1+RD_LAT cycles after accept.
// One grant per cycle via one-hot req_ready; responses are never stalled. SRAM_ARB_CLEAR_EN zeroes the SRAM after reset.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AW      = SRAM_AW_DEF,
    parameter int DW      = SRAM_DW_DEF,
    parameter int RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_wen,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic [AW-1:0]         sram_addr,
    output logic                  sram_wen,
    output logic [DW-1:0]         sram_wdata,
    input  logic [DW-1:0]         sram_rdata
);
    localparam int PW = $clog2(NUM_REQ);

`ifdef SRAM_ARB_CLEAR_EN
    localparam logic [0:0] RST_STATE = ST_INIT;
`else
    localparam logic [0:0] RST_STATE = ST_ARB;
`endif

    typedef struct packed {
        logic          vld;
        logic [PW-1:0] id;
    } rd_tag_t;

    logic [0:0]         state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [AW-1:0]      sram_addr_q, sram_addr_d;
    logic               sram_wen_q, sram_wen_d;
    logic [DW-1:0]      sram_wdata_q, sram_wdata_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]      rsp_rdata_q, rsp_rdata_d;
    rd_tag_t            pipe_q [RD_LAT];
    rd_tag_t            pipe_d [RD_LAT];
`ifdef SRAM_ARB_CLEAR_EN
    logic [AW-1:0]      clr_cnt_q, clr_cnt_d;
`endif

    logic [AW-1:0]      addr_a  [NUM_REQ];
    logic [DW-1:0]      wdata_a [NUM_REQ];
    logic [NUM_REQ-1:0] gnt;
    logic [PW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               arb_en;
    logic               xfer;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_a[i]  = req_addr[i*AW +: AW];
            wdata_a[i] = req_wdata[i*DW +: DW];
        end
    end

    rr_grant #(.N(NUM_REQ), .PW(PW)) u_rr_grant (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Grants are suppressed while rst is high so req_ready reads as its reset value.
    assign arb_en    = (state_q == ST_ARB) && !rst;
    assign req_ready = arb_en ? gnt : '0;
    assign xfer      = arb_en && gnt_any;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        sram_addr_d  = sram_addr_q;
        sram_wen_d   = 1'b0;
        sram_wdata_d = sram_wdata_q;
`ifdef SRAM_ARB_CLEAR_EN
        clr_cnt_d    = clr_cnt_q;
        if (state_q == ST_INIT) begin
            sram_addr_d  = clr_cnt_q;
            sram_wen_d   = 1'b1;
            sram_wdata_d = '0;
            clr_cnt_d    = clr_cnt_q + 1'b1;
            if (&clr_cnt_q) begin
                state_d = ST_ARB;
            end
        end
`endif
        if (xfer) begin
            ptr_d        = PW'(rr_next(32'(gnt_idx), NUM_REQ));
            sram_addr_d  = addr_a[gnt_idx];
            sram_wen_d   = req_wen[gnt_idx];
            sram_wdata_d = wdata_a[gnt_idx];
        end

        // Read tags ride alongside the SRAM latency; the tail tag qualifies sram_rdata.
        pipe_d[0].vld = xfer && !req_wen[gnt_idx];
        pipe_d[0].id  = gnt_idx;
        for (int s = 1; s < RD_LAT; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end

        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (pipe_q[RD_LAT-1].vld) begin
            rsp_valid_d[pipe_q[RD_LAT-1].id] = 1'b1;
            rsp_rdata_d                      = sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RST_STATE;
            ptr_q        <= '0;
            sram_addr_q  <= '0;
            sram_wen_q   <= 1'b0;
            sram_wdata_q <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_q[s] <= '0;
            end
`ifdef SRAM_ARB_CLEAR_EN
            clr_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            sram_addr_q  <= sram_addr_d;
            sram_wen_q   <= sram_wen_d;
            sram_wdata_q <= sram_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            pipe_q       <= pipe_d;
`ifdef SRAM_ARB_CLEAR_EN
            clr_cnt_q    <= clr_cnt_d;
`endif
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_wen   = sram_wen_q;
    assign sram_wdata = sram_wdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;

endmodule
